pipe_drawer: RTL and testbench



---
 rtl/pipe_drawer.sv | 179 +++++++++++++++++
 tb/tb_pipe_drawer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_drawer.sv
// pipe_drawer: outline pixel generator for the lower (ground-side) pipe.
// After a start request it emits one registered (x, y) outline pixel per
// clock. The trace covers the pipe body and a bevelled lip whose top edge
// sits at the latched pipe_y. done pulses on the final pixel.
// Optional build macro PIPE_DRAWER_ABORT_EN: when defined, dropping enable
// while an outline is being drawn abandons that outline.
module pipe_drawer #(
  parameter int PIPE_W   = 50,
  parameter int BEVEL    = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [10:0] pipe_x,
  input  logic [10:0] pipe_y,
  output logic        done,
  output logic [10:0] x,
  output logic [10:0] y
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    S6   = 3'd6,
    S7   = 3'd7
  } state_t;

  // All geometry is carried at 12-bit signed width so that positions left
  // of the screen edge stay negative until they are clamped for output.
  localparam logic signed [11:0] Y_BOT  = 12'(SCREEN_H - 1);
  localparam logic signed [11:0] PY_MAX = 12'(SCREEN_H - 2 - BEVEL);
  localparam logic signed [11:0] X_MAX  = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] BEV    = 12'(BEVEL);
  localparam logic signed [11:0] PW     = 12'(PIPE_W);

  state_t            state;
  logic [11:0]       step;
  logic signed [11:0] geo_bl, geo_br, geo_ll, geo_lr, geo_py, geo_yl;

  logic signed [11:0] in_bl, in_br, in_ll, in_lr, in_py, in_yl;
  logic signed [11:0] cur_x, cur_y, adv_x, adv_y;
  logic               at_end;
  state_t             seg_next, adv_state;
  logic [11:0]        adv_step;

  // Clamp a signed column to the visible range [0, SCREEN_W-1].
  function automatic logic [10:0] clamp_x(input logic signed [11:0] v);
    if (v < 12'sd0) begin
      return 11'd0;
    end else if (v > X_MAX) begin
      return X_MAX[10:0];
    end else begin
      return v[10:0];
    end
  endfunction

  // Pixel at position k of segment s; each segment starts one step past
  // the previous segment's end so every corner is emitted exactly once.
  function automatic logic [23:0] seg_pixel(
    input state_t             s,
    input logic [11:0]        k,
    input logic signed [11:0] g_bl,
    input logic signed [11:0] g_br,
    input logic signed [11:0] g_ll,
    input logic signed [11:0] g_lr,
    input logic signed [11:0] g_py,
    input logic signed [11:0] g_yl
  );
    logic signed [11:0] fx, fy, ks;
    ks = signed'(k);
    fx = 12'sd0;
    fy = 12'sd0;
    case (s)
      S1: begin fx = g_bl;                fy = Y_BOT - ks;          end
      S2: begin fx = g_bl - 12'sd1 - ks;  fy = g_yl;                end
      S3: begin fx = g_ll;                fy = g_yl - 12'sd1 - ks;  end
      S4: begin fx = g_ll + 12'sd1 + ks;  fy = g_py;                end
      S5: begin fx = g_lr;                fy = g_py + 12'sd1 + ks;  end
      S6: begin fx = g_lr - 12'sd1 - ks;  fy = g_yl;                end
      S7: begin fx = g_br;                fy = g_yl + 12'sd1 + ks;  end
      default: begin fx = 12'sd0;         fy = 12'sd0;              end
    endcase
    return {fx, fy};
  endfunction

  // Geometry derived straight from the inputs, used only at start.
  assign in_br = signed'({1'b0, pipe_x});
  assign in_bl = in_br - PW;
  assign in_ll = in_bl - BEV;
  assign in_lr = in_br + BEV;
  assign in_py = (signed'({1'b0, pipe_y}) > PY_MAX) ? PY_MAX : signed'({1'b0, pipe_y});
  assign in_yl = in_py + BEV;

  // Locate the current pixel, detect segment end, and form the next pixel.
  always_comb begin
    {cur_x, cur_y} = seg_pixel(state, step, geo_bl, geo_br, geo_ll,
                               geo_lr, geo_py, geo_yl);
    at_end   = 1'b0;
    seg_next = IDLE;
    case (state)
      S1: begin at_end = (cur_y == geo_yl); seg_next = S2;   end
      S2: begin at_end = (cur_x == geo_ll); seg_next = S3;   end
      S3: begin at_end = (cur_y == geo_py); seg_next = S4;   end
      S4: begin at_end = (cur_x == geo_lr); seg_next = S5;   end
      S5: begin at_end = (cur_y == geo_yl); seg_next = S6;   end
      S6: begin at_end = (cur_x == geo_br); seg_next = S7;   end
      S7: begin at_end = (cur_y == Y_BOT);  seg_next = IDLE; end
      default: begin at_end = 1'b0;         seg_next = IDLE; end
    endcase
    adv_state = at_end ? seg_next : state;
    adv_step  = at_end ? 12'd0 : step + 12'd1;
    {adv_x, adv_y} = seg_pixel(adv_state, adv_step, geo_bl, geo_br, geo_ll,
                               geo_lr, geo_py, geo_yl);
  end

  // Outline FSM with registered pixel and done outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      step   <= 12'd0;
      x      <= 11'd0;
      y      <= 11'd0;
      done   <= 1'b0;
      geo_bl <= 12'sd0;
      geo_br <= 12'sd0;
      geo_ll <= 12'sd0;
      geo_lr <= 12'sd0;
      geo_py <= 12'sd0;
      geo_yl <= 12'sd0;
    end else begin
      case (state)
        IDLE: begin
          step <= 12'd0;
          done <= 1'b0;
          if (enable) begin
            state  <= S1;
            geo_bl <= in_bl;
            geo_br <= in_br;
            geo_ll <= in_ll;
            geo_lr <= in_lr;
            geo_py <= in_py;
            geo_yl <= in_yl;
            x      <= clamp_x(in_bl);
            y      <= Y_BOT[10:0];
          end else begin
            x <= 11'd0;
            y <= 11'd0;
          end
        end
        default: begin
`ifdef PIPE_DRAWER_ABORT_EN
          if (!enable || adv_state == IDLE) begin
`else
          if (adv_state == IDLE) begin
`endif
            state <= IDLE;
            step  <= 12'd0;
            x     <= 11'd0;
            y     <= 11'd0;
            done  <= 1'b0;
          end else begin
            state <= adv_state;
            step  <= adv_step;
            x     <= clamp_x(adv_x);
            y     <= adv_y[10:0];
            done  <= (adv_state == S7) && (adv_y == Y_BOT);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_drawer.sv
// tb_pipe_drawer: scoreboard bench for pipe_drawer. Stimulus pushes the
// expected per-cycle (x, y, done) stream; a monitor pops and compares on
// every falling edge while entries are pending.
module tb_pipe_drawer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [10:0] pipe_x, pipe_y;
  logic        done;
  logic [10:0] x, y;

  pipe_drawer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pipe_x(pipe_x), .pipe_y(pipe_y),
    .done(done), .x(x), .y(y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] ex;
    logic [10:0] ey;
    logic        ed;
  } exp_t;

  exp_t exp_q[$];
  int   obs_x[$];
  int   obs_y[$];
  int   checks = 0;
  int   errors = 0;
  int   pix_cnt = 0;
  int   last_cnt = 0;
  int   done_cnt = 0;
  int   fail_prints = 0;

  // Monitor: compare pending expectations and record drawn pixels.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (x !== e.ex || y !== e.ey || done !== e.ed) begin
        errors++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL pixel t=%0t: got (%0d,%0d,done=%0b) expected (%0d,%0d,done=%0b)",
                   $time, x, y, done, e.ex, e.ey, e.ed);
        end
      end
    end
    if (x == 11'd0 && y == 11'd0) begin
      pix_cnt = 0;
    end else begin
      pix_cnt++;
      obs_x.push_back(int'(x));
      obs_y.push_back(int'(y));
    end
    if (done === 1'b1) begin
      done_cnt++;
      last_cnt = pix_cnt;
    end
  end

  task automatic push_px(input int px, input int py, input bit d);
    exp_t e;
    int cx;
    cx = (px < 0) ? 0 : ((px > 639) ? 639 : px);
    e.ex = 11'(cx);
    e.ey = 11'(py);
    e.ed = d;
    exp_q.push_back(e);
  endtask

  // Reference outline: walk a polyline through the eight corner vertices
  // one unit at a time, then one idle cycle.
  task automatic push_outline(input int px, input int py);
    int pyc, bl, br, ll, lr, yl, cx, cy;
    int vx[8];
    int vy[8];
    pyc = (py > 468) ? 468 : py;
    br = px; bl = px - 50; ll = bl - 10; lr = br + 10; yl = pyc + 10;
    vx = '{bl, bl, ll, ll, lr, lr, br, br};
    vy = '{479, yl, yl, pyc, pyc, yl, yl, 479};
    cx = vx[0];
    cy = vy[0];
    push_px(cx, cy, 1'b0);
    for (int v = 1; v < 8; v++) begin
      while (cx != vx[v] || cy != vy[v]) begin
        if (cx < vx[v]) cx++; else if (cx > vx[v]) cx--;
        if (cy < vy[v]) cy++; else if (cy > vy[v]) cy--;
        push_px(cx, cy, (v == 7 && cy == 479));
      end
    end
    push_px(0, 0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int obs_xa(input int i);
    return (i < obs_x.size()) ? obs_x[i] : -1;
  endfunction

  function automatic int obs_ya(input int i);
    return (i < obs_y.size()) ? obs_y[i] : -1;
  endfunction

  // Start an outline; called half a cycle after a falling edge with DUT idle.
  task automatic start(input int px, input int py);
    pipe_x = 11'(px);
    pipe_y = 11'(py);
    obs_x.delete();
    obs_y.delete();
    enable = 1'b1;
    @(negedge clk); #1;
`ifndef PIPE_DRAWER_ABORT_EN
    enable = 1'b0;
`endif
  endtask

  task automatic drain(input bit drop_on_done);
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk); #1;
      if (drop_on_done && done === 1'b1) enable = 1'b0;
      n++;
      if (n > 3000) begin
        errors++;
        $display("FAIL drain timeout: got %0d pending expected 0", exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic wait_obs(input int n);
    int c;
    c = 0;
    while (obs_x.size() < n) begin
      @(negedge clk); #1;
      c++;
      if (c > 3000) begin
        errors++;
        $display("FAIL wait_obs timeout: got %0d pixels expected %0d", obs_x.size(), n);
        break;
      end
    end
  endtask

  initial begin
    int base, c;
    reset = 1'b1; enable = 1'b0; pipe_x = '0; pipe_y = '0;

    // Reset held two cycles, stays idle afterwards.
    @(posedge clk); #1;
    repeat (3) push_px(0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    drain(1'b0);
    chk("reset_done_cnt", done_cnt, 0);
    $display("reset: idle checked");

    // Basic outline with inputs changed mid-draw.
    push_outline(100, 380);
    start(100, 380);
    wait_obs(120);
    pipe_x = 11'd300; pipe_y = 11'd50;
    drain(1'b1);
    chk("first_x", obs_xa(0), 50);     chk("first_y", obs_ya(0), 479);
    chk("c1_x", obs_xa(89), 50);       chk("c1_y", obs_ya(89), 390);
    chk("c2_x", obs_xa(99), 40);       chk("c2_y", obs_ya(99), 390);
    chk("c3_x", obs_xa(109), 40);      chk("c3_y", obs_ya(109), 380);
    chk("c4_x", obs_xa(179), 110);     chk("c4_y", obs_ya(179), 380);
    chk("c5_x", obs_xa(189), 110);     chk("c5_y", obs_ya(189), 390);
    chk("c6_x", obs_xa(199), 100);     chk("c6_y", obs_ya(199), 390);
    chk("last_x", obs_xa(288), 100);   chk("last_y", obs_ya(288), 479);
    chk("count_basic", last_cnt, 289);
    chk("done_basic", done_cnt, 1);
    $display("outline px=100 py=380: pixels=%0d done_pulses=%0d", last_cnt, done_cnt);

    // Left-edge clamping.
    push_outline(30, 200);
    start(30, 200);
    drain(1'b1);
    chk("clamp_first_x", obs_xa(0), 0);  chk("clamp_first_y", obs_ya(0), 479);
    chk("clamp_s2_x", obs_xa(275), 0);   chk("clamp_s2_y", obs_ya(275), 210);
    chk("clamp_s3_x", obs_xa(285), 0);   chk("clamp_s3_y", obs_ya(285), 204);
    chk("clamp_s4_x", obs_xa(320), 1);   chk("clamp_s4_y", obs_ya(320), 200);
    chk("clamp_last_x", obs_xa(648), 30); chk("clamp_last_y", obs_ya(648), 479);
    chk("count_clamp", last_cnt, 649);
    chk("done_clamp", done_cnt, 2);
    $display("outline px=30 py=200: pixels=%0d done_pulses=%0d", last_cnt, done_cnt);

    // Enable held through done: idle gap then a second identical outline.
    base = done_cnt;
    push_outline(100, 380);
    push_outline(100, 380);
    pipe_x = 11'd100; pipe_y = 11'd380;
    obs_x.delete(); obs_y.delete();
    enable = 1'b1;
    c = 0;
    while (done_cnt < base + 1 && c < 3000) begin
      @(negedge clk); #1;
      c++;
    end
    chk("held_first_done", done_cnt, base + 1);
`ifndef PIPE_DRAWER_ABORT_EN
    @(negedge clk); #1;
    @(negedge clk); #1;
    enable = 1'b0;
`endif
    drain(1'b1);
    repeat (3) push_px(0, 0, 1'b0);
    drain(1'b0);
    chk("held_done", done_cnt, base + 2);
    chk("held_count", last_cnt, 289);
    $display("held enable: two outlines, done_pulses=%0d", done_cnt - base);

    // Reset during S4.
    base = done_cnt;
    push_outline(100, 380);
    start(100, 380);
    wait_obs(150);
    reset = 1'b1; enable = 1'b0;
    exp_q.delete();
    repeat (3) push_px(0, 0, 1'b0);
    @(negedge clk); #1;
    reset = 1'b0;
    drain(1'b0);
    chk("rst_s4_x", obs_xa(149), 80);
    chk("rst_s4_pixels", obs_x.size(), 150);
    chk("rst_s4_done", done_cnt, base);
    $display("reset in S4: pixels=%0d", obs_x.size());

`ifdef PIPE_DRAWER_ABORT_EN
    // Dropping enable in S3 abandons the outline.
    base = done_cnt;
    push_outline(100, 380);
    start(100, 380);
    wait_obs(101);
    enable = 1'b0;
    exp_q.delete();
    repeat (3) push_px(0, 0, 1'b0);
    drain(1'b0);
    chk("abort_pixels", obs_x.size(), 101);
    chk("abort_done", done_cnt, base);
    $display("abort in S3: pixels=%0d", obs_x.size());
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
